// File: rtl/jtdd_gfx_pkg.sv
// Shared definitions for the Double Dragon graphics ROM arbiter:
// client identifiers, FSM encoding and the SDRAM word-address width.
package jtdd_gfx_pkg;

  localparam int SDRAM_AW = 22;

  localparam logic [1:0] CLI_CHAR = 2'd0;
  localparam logic [1:0] CLI_SCR  = 2'd1;
  localparam logic [1:0] CLI_OBJ  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_e;

  // Picks the odd or even byte out of a 16-bit ROM word.
  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    byte_sel = hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/jtdd_gfx_slot.sv
// One-entry tag/data cache for a single ROM client; hit is combinational
// against the current client address, refill comes from the arbiter.
module jtdd_gfx_slot
  import jtdd_gfx_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_tag_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  // Refill next-state: tag is the address latched at grant time, not the live one.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_i) begin
      valid_d = 1'b1;
      tag_d   = wr_tag_i;
      data_d  = wr_data_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (tag_q == addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/jtdd_gfx_arb.sv
// Shares one SDRAM read port between the char, scroll and object fetchers.
// Priority char > scroll > obj, with obj forced through after STARVE_MAX losses.
module jtdd_gfx_arb
  import jtdd_gfx_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h28000,
  parameter int          STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] char_addr_i,
  output logic [7:0]  char_data_o,
  output logic        char_ok_o,
  input  logic [16:0] scr_addr_i,
  output logic [15:0] scr_data_o,
  output logic        scr_ok_o,
  input  logic        obj_cs_i,
  input  logic [17:0] obj_addr_i,
  output logic [31:0] obj_data_o,
  output logic        obj_ok_o,
  output logic [21:0] sdram_addr_o,
  output logic        sdram_req_o,
  input  logic        sdram_ack_i,
  input  logic        sdram_dst_i,
  input  logic [31:0] sdram_data_i
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_e              state_q;
  logic                req_q;
  logic [SDRAM_AW-1:0] addr_q;
  logic [1:0]          id_q;
  logic [17:0]         lat_q;
  logic [7:0]          starve_q, starve_d;

  logic [21:0] char_map, scr_map, obj_map;
  logic        char_hit, scr_hit, obj_hit, busy, dst_wr;
  logic        char_miss, scr_miss, obj_miss;
  logic [15:0] char_word;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic [21:0] gnt_addr;
  logic [17:0] gnt_tag;

  assign char_map = CHAR_OFFSET + {7'd0, char_addr_i[15:1]};
  assign scr_map  = SCR_OFFSET + {5'd0, scr_addr_i};
  assign obj_map  = OBJ_OFFSET + {3'd0, obj_addr_i, 1'b0};

  assign busy      = (state_q != ST_IDLE);
  assign char_miss = !char_hit && !(busy && id_q == CLI_CHAR);
  assign scr_miss  = !scr_hit && !(busy && id_q == CLI_SCR);
  assign obj_miss  = obj_cs_i && !obj_hit && !(busy && id_q == CLI_OBJ);

  // Data lands either in WAIT_DATA or together with the ack; anything else is stale.
  assign dst_wr = sdram_dst_i &&
                  ((state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_ACK && sdram_ack_i));

  // Grant selection: starvation override first, then fixed priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = CLI_CHAR;
    gnt_addr  = char_map;
    gnt_tag   = {2'd0, char_addr_i};
    if (obj_miss && starve_q >= STARVE_LIM) begin
      gnt_valid = 1'b1;
      gnt_id    = CLI_OBJ;
      gnt_addr  = obj_map;
      gnt_tag   = obj_addr_i;
    end else if (char_miss) begin
      gnt_valid = 1'b1;
    end else if (scr_miss) begin
      gnt_valid = 1'b1;
      gnt_id    = CLI_SCR;
      gnt_addr  = scr_map;
      gnt_tag   = {1'b0, scr_addr_i};
    end else if (obj_miss) begin
      gnt_valid = 1'b1;
      gnt_id    = CLI_OBJ;
      gnt_addr  = obj_map;
      gnt_tag   = obj_addr_i;
    end else begin
      gnt_valid = 1'b0;
    end
  end

  // Starvation count: grants lost by a waiting obj request.
  always_comb begin
    starve_d = starve_q;
    if (!obj_miss) begin
      starve_d = 8'd0;
    end else if (state_q == ST_IDLE && gnt_valid) begin
      starve_d = (gnt_id == CLI_OBJ) ? 8'd0 : starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= 8'd0;
    else        starve_q <= starve_d;
  end

  // SDRAM request FSM with registered request/address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= 22'd0;
      id_q    <= CLI_CHAR;
      lat_q   <= 18'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            req_q   <= 1'b1;
            addr_q  <= gnt_addr;
            id_q    <= gnt_id;
            lat_q   <= gnt_tag;
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack_i) begin
            req_q   <= 1'b0;
            state_q <= sdram_dst_i ? ST_IDLE : ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (sdram_dst_i) state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sdram_req_o  = req_q;
  assign sdram_addr_o = addr_q;

  jtdd_gfx_slot #(.AW(16), .DW(16)) u_char_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_i    (char_addr_i),
    .wr_i      (dst_wr && id_q == CLI_CHAR),
    .wr_tag_i  (lat_q[15:0]),
    .wr_data_i (sdram_data_i[15:0]),
    .hit_o     (char_hit),
    .data_o    (char_word)
  );

  jtdd_gfx_slot #(.AW(17), .DW(16)) u_scr_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_i    (scr_addr_i),
    .wr_i      (dst_wr && id_q == CLI_SCR),
    .wr_tag_i  (lat_q[16:0]),
    .wr_data_i (sdram_data_i[15:0]),
    .hit_o     (scr_hit),
    .data_o    (scr_data_o)
  );

  jtdd_gfx_slot #(.AW(18), .DW(32)) u_obj_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_i    (obj_addr_i),
    .wr_i      (dst_wr && id_q == CLI_OBJ),
    .wr_tag_i  (lat_q),
    .wr_data_i (sdram_data_i),
    .hit_o     (obj_hit),
    .data_o    (obj_data_o)
  );

  assign char_data_o = byte_sel(char_word, char_addr_i[0]);
  assign char_ok_o   = char_hit;
  assign scr_ok_o    = scr_hit;
  assign obj_ok_o    = obj_cs_i && obj_hit;

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// Scoreboarded bench for jtdd_gfx_arb: expected SDRAM addresses are queued
// as client addresses are driven and popped when the arbiter raises a request.
module tb_jtdd_gfx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] char_addr;
  logic [7:0]  char_data;
  logic        char_ok;
  logic [16:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [31:0] sdram_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  jtdd_gfx_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_addr_i  (char_addr),
    .char_data_o  (char_data),
    .char_ok_o    (char_ok),
    .scr_addr_i   (scr_addr),
    .scr_data_o   (scr_data),
    .scr_ok_o     (scr_ok),
    .obj_cs_i     (obj_cs),
    .obj_addr_i   (obj_addr),
    .obj_data_o   (obj_data),
    .obj_ok_o     (obj_ok),
    .sdram_addr_o (sdram_addr),
    .sdram_req_o  (sdram_req),
    .sdram_ack_i  (sdram_ack),
    .sdram_dst_i  (sdram_dst),
    .sdram_data_i (sdram_data)
  );

  // Waits (bounded) for sdram_req and checks its address against the scoreboard.
  task automatic wait_req(output int cyc);
    logic [21:0] e;
    cyc = 0;
    for (int k = 1; k <= 40 && cyc == 0; k++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) cyc = k;
    end
    n_cmp++;
    if (cyc == 0) begin
      n_err++;
      $display("FAIL req_timeout: got no sdram_req, want one");
    end else if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL req_unexpected: got request addr %h, want none", sdram_addr);
    end else begin
      e = exp_q.pop_front();
      if (sdram_addr !== e) begin
        n_err++;
        $display("FAIL req_addr: got %h want %h", sdram_addr, e);
      end
    end
  endtask

  task automatic do_ack(input bit same, input logic [31:0] d, input int hold);
    logic [21:0] a0;
    a0 = sdram_addr;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b1 || sdram_addr !== a0) begin
        n_err++;
        $display("FAIL req_hold: got req %b addr %h want 1 %h", sdram_req, sdram_addr, a0);
      end
    end
    sdram_ack = 1'b1;
    if (same) begin
      sdram_dst  = 1'b1;
      sdram_data = d;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    if (same) begin
      n_cmp++;
      if (sdram_req !== 1'b0) begin
        n_err++;
        $display("FAIL idle_gap_same: got req %b want 0", sdram_req);
      end
    end
  endtask

  task automatic do_dst(input logic [31:0] d);
    @(negedge clk);
    sdram_dst  = 1'b1;
    sdram_data = d;
    @(negedge clk);
    sdram_dst = 1'b0;
    n_cmp++;
    if (sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL idle_gap: got req %b want 0", sdram_req);
    end
  endtask

  task automatic serve(input logic [31:0] d);
    int cyc;
    wait_req(cyc);
    do_ack(1'b0, 32'd0, 0);
    do_dst(d);
  endtask

  task automatic test_reset;
    int cyc;
    rst_n = 1'b0;
    char_addr = 16'h0003; scr_addr = 17'h0; obj_cs = 1'b0; obj_addr = 18'h5;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = 32'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sdram_req !== 1'b0 || sdram_addr !== 22'd0 || char_ok !== 1'b0 ||
        scr_ok !== 1'b0 || obj_ok !== 1'b0 || char_data !== 8'd0 || scr_data !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: got req %b addr %h ok %b%b%b cd %h sd %h want all 0",
               sdram_req, sdram_addr, char_ok, scr_ok, obj_ok, char_data, scr_data);
    end
    rst_n = 1'b1;
    exp_q.push_back(22'h00001);
    wait_req(cyc);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sdram_req !== 1'b0 || char_ok !== 1'b0 || scr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midflight: got req %b cok %b sok %b want 0 0 0", sdram_req, char_ok, scr_ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sdram_dst = 1'b1;
    sdram_data = 32'hDEAD_BEEF;
    @(negedge clk);
    sdram_dst = 1'b0;
    n_cmp++;
    if (char_ok !== 1'b0 || scr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL stale_dst: got cok %b sok %b want 0 0", char_ok, scr_ok);
    end
    exp_q.push_back(22'h00001);
    exp_q.push_back(22'h08000);
  endtask

  task automatic test_char_miss;
    int cyc, seen;
    wait_req(cyc);
    do_ack(1'b0, 32'd0, 2);
    do_dst(32'h1234_ABCD);
    n_cmp++;
    if (char_ok !== 1'b1 || char_data !== 8'hAB) begin
      n_err++;
      $display("FAIL char_fill: got ok %b data %h want 1 ab", char_ok, char_data);
    end
    serve(32'hAAAA_5A5A);
    n_cmp++;
    if (scr_ok !== 1'b1 || scr_data !== 16'h5A5A) begin
      n_err++;
      $display("FAIL scr_fill: got ok %b data %h want 1 5a5a", scr_ok, scr_data);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0 || char_ok !== 1'b1) begin
      n_err++;
      $display("FAIL hit_no_req: got %0d request cycles, cok %b want 0, 1", seen, char_ok);
    end
  endtask

  task automatic test_simultaneous;
    char_addr = 16'h0020; scr_addr = 17'h10; obj_cs = 1'b1; obj_addr = 18'h5;
    exp_q.push_back(22'h00010);
    exp_q.push_back(22'h08010);
    exp_q.push_back(22'h2800A);
    serve(32'hFFFF_1E5C);
    serve(32'h0000_BEEF);
    serve(32'hCAFE_F00D);
    n_cmp++;
    if (char_ok !== 1'b1 || char_data !== 8'h5C || scr_ok !== 1'b1 || scr_data !== 16'hBEEF ||
        obj_ok !== 1'b1 || obj_data !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL simul_data: got %b %h %b %h %b %h want 1 5c 1 beef 1 cafef00d",
               char_ok, char_data, scr_ok, scr_data, obj_ok, obj_data);
    end
  endtask

  task automatic test_obj_cs;
    int seen;
    obj_cs = 1'b0;
    #1;
    n_cmp++;
    if (obj_ok !== 1'b0) begin
      n_err++;
      $display("FAIL obj_cs_low_ok: got %b want 0", obj_ok);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (sdram_req === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL obj_cs_low_req: got %0d request cycles want 0", seen);
    end
    obj_cs = 1'b1;
    #1;
    n_cmp++;
    if (obj_ok !== 1'b1 || obj_data !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL obj_cs_hit: got %b %h want 1 cafef00d", obj_ok, obj_data);
    end
  endtask

  task automatic test_starvation;
    @(negedge clk);
    char_addr = 16'h0100; scr_addr = 17'h30; obj_addr = 18'h7;
    for (int i = 0; i < 4; i++) exp_q.push_back(22'h00080 + 22'(i));
    exp_q.push_back(22'h2800E);
    exp_q.push_back(22'h00084);
    exp_q.push_back(22'h08030);
    for (int i = 0; i < 4; i++) begin
      serve(32'h0000_1000 + 32'(i));
      char_addr = 16'h0100 + 16'((i + 1) * 2);
    end
    serve(32'h0B0B_0B0B);
    n_cmp++;
    if (obj_ok !== 1'b1 || obj_data !== 32'h0B0B_0B0B) begin
      n_err++;
      $display("FAIL starve_obj: got %b %h want 1 0b0b0b0b", obj_ok, obj_data);
    end
    serve(32'h0000_0042);
    serve(32'h0000_3333);
    n_cmp++;
    if (char_data !== 8'h42 || scr_data !== 16'h3333) begin
      n_err++;
      $display("FAIL starve_tail: got %h %h want 42 3333", char_data, scr_data);
    end
  endtask

  task automatic test_addr_change;
    int cyc;
    scr_addr = 17'h20;
    exp_q.push_back(22'h08020);
    exp_q.push_back(22'h08021);
    wait_req(cyc);
    do_ack(1'b0, 32'd0, 0);
    scr_addr = 17'h21;
    do_dst(32'h0000_1111);
    n_cmp++;
    if (scr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL addr_change_ok: got %b want 0", scr_ok);
    end
    serve(32'h0000_2222);
    n_cmp++;
    if (scr_ok !== 1'b1 || scr_data !== 16'h2222) begin
      n_err++;
      $display("FAIL addr_change_fill: got %b %h want 1 2222", scr_ok, scr_data);
    end
  endtask

  task automatic test_same_cycle;
    int cyc;
    char_addr = 16'h0041;
    exp_q.push_back(22'h00020);
    wait_req(cyc);
    do_ack(1'b1, 32'h0000_77C3, 1);
    n_cmp++;
    if (char_ok !== 1'b1 || char_data !== 8'h77) begin
      n_err++;
      $display("FAIL same_cycle: got %b %h want 1 77", char_ok, char_data);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    char_addr = 16'h0050; scr_addr = 17'h40;
    exp_q.push_back(22'h00028);
    exp_q.push_back(22'h08040);
    serve(32'h0000_0099);
    wait_req(cyc);
    n_cmp++;
    if (cyc != 1) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d cycles want 1", cyc);
    end
    do_ack(1'b0, 32'd0, 0);
    do_dst(32'h0000_4444);
    n_cmp++;
    if (char_data !== 8'h99 || scr_data !== 16'h4444 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_data: got %h %h left %0d want 99 4444 0", char_data, scr_data, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_char_miss();
    test_simultaneous();
    test_obj_cs();
    test_starvation();
    test_addr_change();
    test_same_cycle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
